axi4_lite_protocol_checker: RTL and testbench
=============================================

Name: axi4_lite_protocol_checker

Overview:
- Passive, parametrised AXI4-Lite bus monitor. It samples all five channels, checks handshake and payload-stability rules, and tracks outstanding read/write transactions against a configured depth.
- It also detects response-without-request and stalled-transaction timeouts.
- Errors are reported as a sticky vector plus a first-error capture.
- It sits alongside any axi4_lite interface instance, in both testbench and synthesisable debug builds. It never drives the bus.

Parameters:
- A, 32, address width in bits.
- N, 4, data width in bytes; wstrb is N bits.
- MAX_OUT, 4, maximum outstanding transactions per direction (1..15).
- TIMEOUT, 1024, cycles a transaction may stay outstanding without progress; 0 disables the timeout checks.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- araddr/awaddr  in  A  read/write address.
- arprot/awprot  in  3  protection bits.
- arvalid/arready/awvalid/awready  in  1  address handshakes.
- wdata  in  8*N  write data.
- wstrb  in  N  write strobes.
- wvalid/wready  in  1  write-data handshake.
- bresp  in  2  write response.
- bvalid/bready  in  1  write-response handshake.
- rdata  in  8*N  read data.
- rresp  in  2  read response.
- rvalid/rready  in  1  read-data handshake.
- clear  in  1  synchronous clear of err and first_err.
- err  out  11  sticky error flags (bit map below).
- err_pulse  out  1  high one cycle when any err bit newly sets.
- first_err  out  4  index of the first error set since reset/clear; 4'hF = none.
- wr_out  out  4  outstanding writes (AW accepted minus B accepted).
- rd_out  out  4  outstanding reads.

Behaviour:
- Reset (areset=1, asynchronous): err=0, err_pulse=0, first_err=4'hF, wr_out=0, rd_out=0, all internal counters and registers 0. No check fires while areset=1, nor in the first cycle after release.
- Handshake on channel X = Xvalid & Xready at a rising edge of aclk.
- Stability checks use a per-channel "pending" register, set when valid=1 and ready=0. In the next cycle, valid low or any payload change sets the error. Payload per channel:
  - AR: araddr, arprot.
  - AW: awaddr, awprot.
  - W: wdata, wstrb.
  - R: rdata, rresp.
  - B: bresp.
- err bit map:
  - 0 AR unstable; 1 AW unstable; 2 W unstable; 3 R unstable; 4 B unstable.
  - 5 AW handshake with wr_out==MAX_OUT; 6 AR handshake with rd_out==MAX_OUT.
  - 7 B handshake with no eligible write; 8 R handshake with rd_out==0.
  - 9 write timeout; 10 read timeout.
- Write tracking: aw_cnt and w_cnt count accepted AW and W beats, each decremented on B.
  - A B is eligible only if aw_cnt>0 and w_cnt>0 before the current edge. A same-cycle AW/W does not qualify B.
  - wr_out = aw_cnt.
  - On overflow (bit 5) the count saturates at MAX_OUT. On an illegal B (bit 7) counts stay unchanged and never underflow.
- Simultaneous AW and B (both legal): wr_out unchanged. Same rule for AR and R on rd_out.
- Timeout: a per-direction counter runs while its outstanding count >0. It resets to 0 on any handshake in that direction (AW/W/B or AR/R) and whenever the count is 0. Reaching TIMEOUT sets bit 9/10 once; the counter holds until progress.
- err bits are sticky until clear or reset. first_err latches the lowest-indexed bit among those newly set in the first error cycle.
- clear=1 coincident with a new error: the new error wins. err gets that bit only; first_err gets its index.
- err_pulse is registered: high the cycle after new bits latch.
- Simulation only (translate_off): $error on any X on a valid/ready signal while areset=0.

Test Plan:
- Reset, then clean write (AW=0x10 and W same cycle, B OKAY 3 cycles later) and clean read → err=0, first_err=F, wr_out 0→1→0, rd_out 0→1→0.
- arvalid=1, arready=0, araddr=0x40; next cycle araddr=0x44 → err[0]=1, first_err=0, err_pulse high exactly one cycle.
- MAX_OUT=4: five AW handshakes, no B → wr_out saturates at 4, err[5]=1; then 4 B → wr_out=0, no further errors.
- B handshake in the same cycle as the first AW/W → err[7]=1, wr_out ends at 1.
- TIMEOUT=16: one AR accepted, rvalid held low → err[10] sets on cycle 16 after acceptance; an R then returns rd_out to 0.
- Assert areset mid-transaction (wr_out=2) → all outputs reset immediately; clear together with a new W-stability error → err=0x004, first_err=2.

Source files
------------

// File: rtl/axi4_lite_protocol_checker.sv
// Passive AXI4-Lite protocol monitor. Samples all five channels, flags
// handshake/payload stability violations, outstanding-count over/underflow,
// responses without requests and stalled-transaction timeouts.
// Ports:
//   aclk, areset               clock, async active-high reset
//   ar*/aw*/w*/b*/r*           AXI4-Lite channel signals (inputs only)
//   clear                      synchronous clear of err/first_err
//   err[10:0]                  sticky error flags
//   err_pulse                  one-cycle pulse when any err bit newly sets
//   first_err[3:0]             lowest index set in the first error cycle, F = none
//   wr_out, rd_out             outstanding write / read transactions
module axi4_lite_protocol_checker #(
  parameter int unsigned A       = 32,
  parameter int unsigned N       = 4,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic [A-1:0]   araddr,
  input  logic [2:0]     arprot,
  input  logic           arvalid,
  input  logic           arready,
  input  logic [A-1:0]   awaddr,
  input  logic [2:0]     awprot,
  input  logic           awvalid,
  input  logic           awready,
  input  logic [8*N-1:0] wdata,
  input  logic [N-1:0]   wstrb,
  input  logic           wvalid,
  input  logic           wready,
  input  logic [1:0]     bresp,
  input  logic           bvalid,
  input  logic           bready,
  input  logic [8*N-1:0] rdata,
  input  logic [1:0]     rresp,
  input  logic           rvalid,
  input  logic           rready,
  input  logic           clear,
  output logic [10:0]    err,
  output logic           err_pulse,
  output logic [3:0]     first_err,
  output logic [3:0]     wr_out,
  output logic [3:0]     rd_out
);

  localparam int unsigned DW      = 8 * N;
  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [3:0]  MAX_CNT = 4'(MAX_OUT);
  localparam logic [3:0]  NONE    = 4'hF;

  logic armed;
  logic pend_ar, pend_aw, pend_w, pend_r, pend_b;
  logic [A+2:0]    ar_q, aw_q;
  logic [DW+N-1:0] w_q;
  logic [DW+1:0]   r_q;
  logic [1:0]      b_q;
  logic [3:0]      aw_cnt, w_cnt, rd_cnt;
  logic [TW-1:0]   wto_cnt, rto_cnt;

  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic b_legal, r_legal, wr_stall, rd_stall;
  logic [10:0] new_err, newly, err_d;
  logic [3:0]  first_d, low_idx;

  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign r_hs  = rvalid & rready;
  assign b_hs  = bvalid & bready;

  // Eligibility uses counts from before this edge, so same-cycle AW/W never qualify B.
  assign b_legal  = (aw_cnt != '0) && (w_cnt != '0);
  assign r_legal  = (rd_cnt != '0);
  assign wr_stall = (aw_cnt != '0) && !(aw_hs || w_hs || b_hs);
  assign rd_stall = (rd_cnt != '0) && !(ar_hs || r_hs);

  // Add one, remove one, clamp at the configured depth.
  function automatic logic [3:0] cnt_next(input logic [3:0] cur, input logic inc,
                                          input logic dec);
    logic [4:0] s;
    s = {1'b0, cur} + 5'(inc) - 5'(dec);
    return (s > {1'b0, MAX_CNT}) ? MAX_CNT : s[3:0];
  endfunction

  // Error detection for the current edge.
  always_comb begin
    new_err = '0;
    if (armed) begin
      new_err[0]  = pend_ar & (~arvalid | ({araddr, arprot} != ar_q));
      new_err[1]  = pend_aw & (~awvalid | ({awaddr, awprot} != aw_q));
      new_err[2]  = pend_w  & (~wvalid  | ({wdata, wstrb}   != w_q));
      new_err[3]  = pend_r  & (~rvalid  | ({rdata, rresp}   != r_q));
      new_err[4]  = pend_b  & (~bvalid  | (bresp            != b_q));
      new_err[5]  = aw_hs & (aw_cnt == MAX_CNT);
      new_err[6]  = ar_hs & (rd_cnt == MAX_CNT);
      new_err[7]  = b_hs & ~b_legal;
      new_err[8]  = r_hs & ~r_legal;
      new_err[9]  = (TIMEOUT != 0) && wr_stall && (wto_cnt == TW'(TO_LAST));
      new_err[10] = (TIMEOUT != 0) && rd_stall && (rto_cnt == TW'(TO_LAST));
    end
  end

  // Sticky flag update; a clear coincident with new errors keeps only the new ones.
  always_comb begin
    newly   = clear ? new_err : (new_err & ~err);
    err_d   = clear ? new_err : (err | new_err);
    low_idx = NONE;
    for (int i = 10; i >= 0; i--) begin
      if (newly[i]) low_idx = 4'(i);
    end
    first_d = clear ? NONE : first_err;
    if (first_d == NONE && newly != '0) first_d = low_idx;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      armed     <= 1'b0;
      pend_ar   <= 1'b0;
      pend_aw   <= 1'b0;
      pend_w    <= 1'b0;
      pend_r    <= 1'b0;
      pend_b    <= 1'b0;
      ar_q      <= '0;
      aw_q      <= '0;
      w_q       <= '0;
      r_q       <= '0;
      b_q       <= '0;
      aw_cnt    <= '0;
      w_cnt     <= '0;
      rd_cnt    <= '0;
      wto_cnt   <= '0;
      rto_cnt   <= '0;
      err       <= '0;
      err_pulse <= 1'b0;
      first_err <= NONE;
    end else begin
      armed     <= 1'b1;
      pend_ar   <= arvalid & ~arready;
      pend_aw   <= awvalid & ~awready;
      pend_w    <= wvalid & ~wready;
      pend_r    <= rvalid & ~rready;
      pend_b    <= bvalid & ~bready;
      ar_q      <= {araddr, arprot};
      aw_q      <= {awaddr, awprot};
      w_q       <= {wdata, wstrb};
      r_q       <= {rdata, rresp};
      b_q       <= bresp;
      aw_cnt    <= cnt_next(aw_cnt, aw_hs, b_hs & b_legal);
      w_cnt     <= cnt_next(w_cnt, w_hs, b_hs & b_legal);
      rd_cnt    <= cnt_next(rd_cnt, ar_hs, r_hs & r_legal);
      // Stall counters hold at TIMEOUT so each stall reports only once.
      if (!wr_stall)                    wto_cnt <= '0;
      else if (wto_cnt != TW'(TIMEOUT)) wto_cnt <= wto_cnt + TW'(1);
      if (!rd_stall)                    rto_cnt <= '0;
      else if (rto_cnt != TW'(TIMEOUT)) rto_cnt <= rto_cnt + TW'(1);
      err       <= err_d;
      err_pulse <= (newly != '0);
      first_err <= first_d;
    end
  end

  assign wr_out = aw_cnt;
  assign rd_out = rd_cnt;

`ifndef SYNTHESIS
  // Unknown values on handshake signals make every other check meaningless.
  a_no_x_handshake: assert property (@(posedge aclk) disable iff (areset)
    !$isunknown({arvalid, arready, awvalid, awready, wvalid, wready,
                 bvalid, bready, rvalid, rready}))
    else $error("X on AXI4-Lite valid/ready");
`endif

endmodule

// File: tb/tb_axi4_lite_protocol_checker.sv
// Bench for axi4_lite_protocol_checker: directed scenarios followed by random
// channel traffic, all compared each cycle against a rule-level reference model.
module tb_axi4_lite_protocol_checker;

  localparam int unsigned A       = 32;
  localparam int unsigned N       = 4;
  localparam int unsigned DW      = 8 * N;
  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned TIMEOUT = 16;

  logic aclk = 1'b0;
  logic areset;
  logic [A-1:0] araddr, awaddr;
  logic [2:0] arprot, awprot;
  logic arvalid, arready, awvalid, awready;
  logic [DW-1:0] wdata, rdata;
  logic [N-1:0] wstrb;
  logic wvalid, wready;
  logic [1:0] bresp, rresp;
  logic bvalid, bready, rvalid, rready;
  logic clear;
  logic [10:0] err;
  logic err_pulse;
  logic [3:0] first_err, wr_out, rd_out;

  always #5 aclk = ~aclk;

  axi4_lite_protocol_checker #(.A(A), .N(N), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .areset(areset),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .clear(clear), .err(err), .err_pulse(err_pulse), .first_err(first_err),
    .wr_out(wr_out), .rd_out(rd_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: plain integers, last-progress timestamps for timeouts.
  logic [10:0] m_err;
  logic [3:0]  m_first;
  logic        m_pulse;
  int m_aw, m_w, m_rd;
  int cyc = 0, w_mark = 0, r_mark = 0;
  bit m_armed;
  bit p_ar, p_aw, p_w, p_r, p_b;
  logic [A+2:0] s_ar, s_aw;
  logic [DW+N-1:0] s_w;
  logic [DW+1:0] s_r;
  logic [1:0] s_b;

  function automatic logic [3:0] lowest(input logic [10:0] v);
    for (int i = 0; i < 11; i++) if (v[i]) return 4'(i);
    return 4'hF;
  endfunction

  function automatic int clamp(input int v);
    return (v > int'(MAX_OUT)) ? int'(MAX_OUT) : v;
  endfunction

  task automatic model_edge();
    logic [10:0] ne;
    logic [10:0] nw;
    int awh, wh, bh, arh, rh, bdec, rdec;
    bit wstall, rstall;
    cyc++;
    ne  = '0;
    awh = (awvalid && awready) ? 1 : 0;
    wh  = (wvalid && wready) ? 1 : 0;
    bh  = (bvalid && bready) ? 1 : 0;
    arh = (arvalid && arready) ? 1 : 0;
    rh  = (rvalid && rready) ? 1 : 0;
    wstall = (m_aw > 0) && (awh + wh + bh == 0);
    rstall = (m_rd > 0) && (arh + rh == 0);
    if (m_armed) begin
      if (p_ar && (!arvalid || {araddr, arprot} != s_ar)) ne[0] = 1'b1;
      if (p_aw && (!awvalid || {awaddr, awprot} != s_aw)) ne[1] = 1'b1;
      if (p_w  && (!wvalid  || {wdata, wstrb}   != s_w))  ne[2] = 1'b1;
      if (p_r  && (!rvalid  || {rdata, rresp}   != s_r))  ne[3] = 1'b1;
      if (p_b  && (!bvalid  || bresp            != s_b))  ne[4] = 1'b1;
      if (awh == 1 && m_aw == int'(MAX_OUT)) ne[5] = 1'b1;
      if (arh == 1 && m_rd == int'(MAX_OUT)) ne[6] = 1'b1;
      if (bh == 1 && !(m_aw > 0 && m_w > 0)) ne[7] = 1'b1;
      if (rh == 1 && m_rd == 0) ne[8] = 1'b1;
      if (wstall && cyc - w_mark == int'(TIMEOUT)) ne[9] = 1'b1;
      if (rstall && cyc - r_mark == int'(TIMEOUT)) ne[10] = 1'b1;
    end
    if (!wstall) w_mark = cyc;
    if (!rstall) r_mark = cyc;
    bdec = (bh == 1 && m_aw > 0 && m_w > 0) ? 1 : 0;
    rdec = (rh == 1 && m_rd > 0) ? 1 : 0;
    m_aw = clamp(m_aw + awh - bdec);
    m_w  = clamp(m_w + wh - bdec);
    m_rd = clamp(m_rd + arh - rdec);
    nw = clear ? ne : (ne & ~m_err);
    if (clear) begin
      m_err   = ne;
      m_first = lowest(ne);
    end else begin
      m_err = m_err | ne;
      if (m_first == 4'hF) m_first = lowest(nw);
    end
    m_pulse = (nw != '0);
    p_ar = arvalid && !arready;  s_ar = {araddr, arprot};
    p_aw = awvalid && !awready;  s_aw = {awaddr, awprot};
    p_w  = wvalid && !wready;    s_w  = {wdata, wstrb};
    p_r  = rvalid && !rready;    s_r  = {rdata, rresp};
    p_b  = bvalid && !bready;    s_b  = bresp;
    m_armed = 1'b1;
  endtask

  task automatic step();
    model_edge();
    @(posedge aclk);
    #1;
    check("err", 32'(err), 32'(m_err));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("first_err", 32'(first_err), 32'(m_first));
    check("wr_out", 32'(wr_out), 32'(m_aw));
    check("rd_out", 32'(rd_out), 32'(m_rd));
  endtask

  task automatic idle();
    arvalid = 0; arready = 0; awvalid = 0; awready = 0; wvalid = 0; wready = 0;
    bvalid = 0; bready = 0; rvalid = 0; rready = 0; clear = 0;
  endtask

  task automatic do_reset();
    idle();
    areset = 1'b1;
    #1;
    check("rst_err", 32'(err), 32'h0);
    check("rst_pulse", 32'(err_pulse), 32'h0);
    check("rst_first", 32'(first_err), 32'hF);
    check("rst_wr_out", 32'(wr_out), 32'h0);
    check("rst_rd_out", 32'(rd_out), 32'h0);
    m_err = '0; m_first = 4'hF; m_pulse = 1'b0;
    m_aw = 0; m_w = 0; m_rd = 0; m_armed = 1'b0;
    p_ar = 0; p_aw = 0; p_w = 0; p_r = 0; p_b = 0;
    w_mark = cyc; r_mark = cyc;
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic aw_w_beat();
    awvalid = 1; awready = 1; wvalid = 1; wready = 1;
  endtask

  initial begin
    araddr = '0; arprot = '0; awaddr = '0; awprot = '0; wdata = '0; wstrb = '0;
    rdata = '0; rresp = '0; bresp = '0;
    do_reset();
    idle(); step();

    // Clean write then clean read.
    awaddr = 32'h10; wdata = 32'hCAFE_0001; wstrb = 4'hF; aw_w_beat(); step();
    check("t1_wr_out_1", 32'(wr_out), 32'd1);
    idle(); step(); step();
    bvalid = 1; bready = 1; bresp = 2'b00; step();
    check("t1_wr_out_0", 32'(wr_out), 32'd0);
    idle(); araddr = 32'h20; arvalid = 1; arready = 1; step();
    check("t1_rd_out_1", 32'(rd_out), 32'd1);
    idle(); step();
    rvalid = 1; rready = 1; rdata = 32'h1234; step();
    check("t1_rd_out_0", 32'(rd_out), 32'd0);
    check("t1_err", 32'(err), 32'h0);
    check("t1_first", 32'(first_err), 32'hF);

    // AR payload changes while stalled.
    idle(); arvalid = 1; arready = 0; araddr = 32'h40; step();
    araddr = 32'h44; step();
    check("t2_err", 32'(err), 32'h001);
    check("t2_first", 32'(first_err), 32'h0);
    check("t2_pulse_hi", 32'(err_pulse), 32'h1);
    idle(); step();
    check("t2_pulse_lo", 32'(err_pulse), 32'h0);
    clear = 1; step(); clear = 0;
    check("t2_cleared", 32'(err), 32'h0);

    // Write overflow saturates, then drain.
    repeat (5) begin idle(); aw_w_beat(); step(); end
    check("t3_wr_sat", 32'(wr_out), 32'd4);
    check("t3_err", 32'(err), 32'h020);
    repeat (4) begin idle(); bvalid = 1; bready = 1; step(); end
    check("t3_wr_drain", 32'(wr_out), 32'd0);
    check("t3_err_same", 32'(err), 32'h020);
    idle(); clear = 1; step();

    // B coincident with the first AW/W is not eligible.
    idle(); aw_w_beat(); bvalid = 1; bready = 1; step();
    check("t4_err", 32'(err), 32'h080);
    check("t4_wr_out", 32'(wr_out), 32'd1);
    idle(); bvalid = 1; bready = 1; step();
    idle(); clear = 1; step();

    // Read timeout after TIMEOUT stalled cycles.
    idle(); arvalid = 1; arready = 1; step();
    idle(); repeat (TIMEOUT - 1) step();
    check("t5_no_to_yet", 32'(err), 32'h0);
    step();
    check("t5_to", 32'(err), 32'h400);
    check("t5_first", 32'(first_err), 32'hA);
    rvalid = 1; rready = 1; step();
    check("t5_rd_out", 32'(rd_out), 32'd0);
    idle(); clear = 1; step();

    // Reset mid-transaction, then clear racing a new W-stability error.
    idle(); aw_w_beat(); step(); step();
    check("t6_wr_out_2", 32'(wr_out), 32'd2);
    do_reset();
    idle(); step();
    bvalid = 1; bready = 1; step();
    idle(); wvalid = 1; wready = 0; wdata = 32'h1; step();
    wdata = 32'h2; clear = 1; step();
    check("t6_err", 32'(err), 32'h004);
    check("t6_first", 32'(first_err), 32'h2);
    do_reset();

    // Random traffic with occasional quiet spells, clears and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 149) == 0) begin
        idle();
        repeat (TIMEOUT + 4) step();
      end
      arvalid = 1'($urandom_range(0, 1)); arready = 1'($urandom_range(0, 1));
      awvalid = 1'($urandom_range(0, 1)); awready = 1'($urandom_range(0, 1));
      wvalid  = 1'($urandom_range(0, 1)); wready  = 1'($urandom_range(0, 1));
      bvalid  = 1'($urandom_range(0, 1)); bready  = 1'($urandom_range(0, 1));
      rvalid  = 1'($urandom_range(0, 1)); rready  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin araddr = A'($urandom); arprot = 3'($urandom); end
      if ($urandom_range(0, 3) == 0) begin awaddr = A'($urandom); awprot = 3'($urandom); end
      if ($urandom_range(0, 3) == 0) begin wdata = DW'($urandom); wstrb = N'($urandom); end
      if ($urandom_range(0, 3) == 0) begin rdata = DW'($urandom); rresp = 2'($urandom); end
      if ($urandom_range(0, 3) == 0) bresp = 2'($urandom);
      clear = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
